// File: rtl/key_entry_fifo.sv
// Keypad raw-code decoder feeding a DEPTH-entry hex-digit FIFO with a valid/ready output.
// Optional macro KEYCODE_CHECK_EN: reject row nibbles that are not exactly one-cold.
module key_entry_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        key_code,
  input  logic              key_valid,
  input  logic              clear,
  output logic [3:0]        out_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fill_count,
  output logic              full,
  output logic              overflow,
  output logic              err_invalid
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [3:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [ADDR_W:0]   count_next;
  logic [1:0]        row_idx;
  logic              row_ok;
  logic [3:0]        digit;
  logic              pop, push_ok, wr_en;
  logic [3:0]        head_next;

  always_comb begin
    row_ok  = 1'b1;
    row_idx = 2'd3;
`ifdef KEYCODE_CHECK_EN
    case (key_code[3:0])
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      4'b1110: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
`else
    // highest zero bit wins; an all-ones nibble falls through to row 3
    if      (!key_code[3]) row_idx = 2'd0;
    else if (!key_code[2]) row_idx = 2'd1;
    else if (!key_code[1]) row_idx = 2'd2;
    else                   row_idx = 2'd3;
`endif
  end

  always_comb begin
    case ({row_idx, key_code[5:4]})
      4'b00_00: digit = 4'h1;  4'b00_01: digit = 4'h2;
      4'b00_10: digit = 4'h3;  4'b00_11: digit = 4'hA;
      4'b01_00: digit = 4'h4;  4'b01_01: digit = 4'h5;
      4'b01_10: digit = 4'h6;  4'b01_11: digit = 4'hB;
      4'b10_00: digit = 4'h7;  4'b10_01: digit = 4'h8;
      4'b10_10: digit = 4'h9;  4'b10_11: digit = 4'hC;
      4'b11_00: digit = 4'hE;  4'b11_01: digit = 4'h0;
      4'b11_10: digit = 4'hF;  default:  digit = 4'hD;
    endcase
  end

  assign out_valid = (fill_count != '0);
  assign full      = (fill_count == DEPTH_C);
  assign pop       = out_valid & out_ready & ~clear;
  assign push_ok   = key_valid & row_ok & ~clear;
  assign wr_en     = push_ok & (~full | pop);
  assign rd_next   = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;

  always_comb begin
    case ({wr_en, pop})
      2'b10:   count_next = fill_count + 1'b1;
      2'b01:   count_next = fill_count - 1'b1;
      default: count_next = fill_count;
    endcase
  end

  // The head register tracks the entry rd_next will point at, including a same-cycle write.
  assign head_next = (wr_en && (wr_ptr == rd_next)) ? digit : mem[rd_next];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_count  <= '0;
      overflow    <= 1'b0;
      err_invalid <= 1'b0;
      out_digit   <= 4'h0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_count  <= '0;
      overflow    <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr     <= rd_next;
      fill_count <= count_next;
      if (push_ok && full && !pop) overflow <= 1'b1;
`ifdef KEYCODE_CHECK_EN
      if (key_valid && !row_ok) err_invalid <= 1'b1;
`endif
      if (count_next != '0) out_digit <= head_next;
    end
  end

endmodule

// File: tb/tb_key_entry_fifo.sv
// Randomized and directed checks of key_entry_fifo against a queue-based reference model.
module tb_key_entry_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        key_code;
  logic              key_valid;
  logic              clear;
  logic [3:0]        out_digit;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   fill_count;
  logic              full;
  logic              overflow;
  logic              err_invalid;

  key_entry_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .clear(clear), .out_digit(out_digit), .out_valid(out_valid),
    .out_ready(out_ready), .fill_count(fill_count), .full(full),
    .overflow(overflow), .err_invalid(err_invalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] dig_tab [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  logic [3:0] mq[$];
  bit         m_ovf, m_err;
  logic [3:0] m_head;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_decode(input logic [5:0] kc, output logic [3:0] d);
    int row = 3;
    int zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!kc[i]) begin
        zeros++;
        row = 3 - i;
      end
    end
    d = dig_tab[row][kc[5:4]];
`ifdef KEYCODE_CHECK_EN
    return (zeros == 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_err = 0;
    m_head = 4'h0;
  endtask

  task automatic model_update();
    logic [3:0] d;
    bit ok, was_full, do_pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (clear) begin
      mq.delete();
      m_ovf = 0;
      m_err = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && out_ready;
    ok       = model_decode(key_code, d);
    if (do_pop) void'(mq.pop_front());
    if (key_valid) begin
      if (!ok) m_err = 1;
      else if (!was_full || do_pop) mq.push_back(d);
      else m_ovf = 1;
    end
    if (mq.size() > 0) m_head = mq[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},    int'(fill_count),  mq.size());
    chk({tag, ".valid"},    int'(out_valid),   int'(mq.size() > 0));
    chk({tag, ".full"},     int'(full),        int'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, int'(overflow),    int'(m_ovf));
    chk({tag, ".err_inv"},  int'(err_invalid), int'(m_err));
    chk({tag, ".digit"},    int'(out_digit),   int'(m_head));
  endtask

  task automatic drive(input logic kv, input logic [5:0] kc, input logic rdy, input logic clr);
    key_valid = kv;
    key_code  = kc;
    out_ready = rdy;
    clear     = clr;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [5:0] rand_code();
    logic [3:0] nib;
    case ($urandom_range(0, 4))
      0: nib = 4'b0111;
      1: nib = 4'b1011;
      2: nib = 4'b1101;
      3: nib = 4'b1110;
      default: nib = 4'($urandom);
    endcase
    return {2'($urandom), nib};
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1) two pushes, then drain
    drive(1'b1, 6'b00_0111, 1'b0, 1'b0); step("t1.push1");
    chk("t1.digit1", int'(out_digit), 4'h1);
    drive(1'b1, 6'b11_1110, 1'b0, 1'b0); step("t1.push2");
    drive(1'b0, 6'h0, 1'b1, 1'b0);       step("t1.pop1");
    chk("t1.digitD", int'(out_digit), 4'hD);
    step("t1.pop2");
    chk("t1.empty", int'(fill_count), 0);

    // 2) nine pushes into eight slots, then drain
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, {2'(i), 4'b1011}, 1'b0, 1'b0);
      step("t2.fill");
    end
    chk("t2.full", int'(full), 1);
    chk("t2.ovf", int'(overflow), 1);
    drive(1'b0, 6'h0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("t2.drain");

    // 3) full FIFO with simultaneous push and pop
    drive(1'b0, 6'h0, 1'b0, 1'b1); step("t3.clr");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {2'(i), 4'b0111}, 1'b0, 1'b0);
      step("t3.fill");
    end
    drive(1'b1, 6'b01_1101, 1'b1, 1'b0); step("t3.pushpop");
    chk("t3.count", int'(fill_count), 8);
    chk("t3.noovf", int'(overflow), 0);
    drive(1'b0, 6'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("t3.drain");
    chk("t3.last", int'(out_digit), 4'h8);
    step("t3.drain");

    // 4) clear wins over a same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b10_1110, 1'b0, 1'b0);
      step("t4.fill");
    end
    drive(1'b1, 6'b00_0111, 1'b1, 1'b1); step("t4.clear");
    chk("t4.count", int'(fill_count), 0);

    // 5) malformed row nibble
    drive(1'b1, 6'b10_0011, 1'b0, 1'b0); step("t5.bad");
    drive(1'b0, 6'h0, 1'b0, 1'b1);       step("t5.clr");

    // 6) asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {2'(i), 4'b1101}, 1'b0, 1'b0);
      step("t6.fill");
    end
    drive(1'b0, 6'h0, 1'b1, 1'b0); step("t6.drain");
    #2 rst_n = 1'b0;
    #1;
    chk("t6.valid", int'(out_valid), 0);
    chk("t6.count", int'(fill_count), 0);
    model_reset();
    @(negedge clk);
    check_all("t6.held");
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 2) != 0), rand_code(),
            1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
